// File: rtl/iq_sample_fifo_if.sv
// iq_sample_fifo_if: push/pull bus of the IQ sample FIFO.
//   slave  modport: FIFO side (takes PushIn/SampI/SampQ/Flush/PullOut, drives status and head data)
//   master modport: user side (drives requests and samples, observes status and head data)
interface iq_sample_fifo_if #(
    parameter int DWIDTH = 24,
    parameter int DEPTH  = 4
);
    logic                     PushIn;
    logic                     StopIn;
    logic [DWIDTH-1:0]        SampI;
    logic [DWIDTH-1:0]        SampQ;
    logic                     Flush;
    logic                     PullOut;
    logic                     ValidOut;
    logic [DWIDTH-1:0]        OutI;
    logic [DWIDTH-1:0]        OutQ;
    logic [$clog2(DEPTH):0]   Count;
    logic                     AlmostFull;
    logic                     Overflow;
    logic                     Underflow;

    modport slave (
        input  PushIn, SampI, SampQ, Flush, PullOut,
        output StopIn, ValidOut, OutI, OutQ, Count, AlmostFull, Overflow, Underflow
    );

    modport master (
        output PushIn, SampI, SampQ, Flush, PullOut,
        input  StopIn, ValidOut, OutI, OutQ, Count, AlmostFull, Overflow, Underflow
    );
endinterface

// File: rtl/iq_sample_fifo.sv
// iq_sample_fifo: parametrised first-word-fall-through FIFO of paired I/Q samples.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : slave side of iq_sample_fifo_if (PushIn/StopIn input handshake, PullOut/ValidOut
//           output handshake, Flush, Count, AlmostFull, sticky Overflow/Underflow)
module iq_sample_fifo #(
    parameter int DWIDTH    = 24,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic            Clk,
    input  logic            Reset,
    iq_sample_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_nxt;
    logic                stop, valid, afull, ovf, udf;
    logic                wr_en, rd_en;

    assign wr_en = bus.PushIn & ~stop;
    assign rd_en = bus.PullOut & valid;

    always_comb begin
        count_nxt = (wr_en && !rd_en) ? count + CW'(1) :
                    (rd_en && !wr_en) ? count - CW'(1) : count;
    end

    // Status flags are registered from count_nxt so they move only on an edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            stop   <= 1'b0;
            valid  <= 1'b0;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (bus.Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            stop   <= 1'b0;
            valid  <= 1'b0;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            stop  <= count_nxt == CW'(DEPTH);
            valid <= count_nxt != '0;
            afull <= count_nxt >= CW'(AFULL_LVL);
            ovf   <= ovf | (bus.PushIn & stop);
            udf   <= udf | (bus.PullOut & ~valid);
        end
    end

    // Storage is deliberately left unreset; pointers alone define what is valid.
    always_ff @(posedge Clk) begin
        if (wr_en && !bus.Flush) mem[wr_ptr] <= {bus.SampI, bus.SampQ};
    end

    assign bus.StopIn     = stop;
    assign bus.ValidOut   = valid;
    assign bus.Count      = count;
    assign bus.AlmostFull = afull;
    assign bus.Overflow   = ovf;
    assign bus.Underflow  = udf;
    assign bus.OutI       = valid ? mem[rd_ptr][2*DWIDTH-1:DWIDTH] : '0;
    assign bus.OutQ       = valid ? mem[rd_ptr][DWIDTH-1:0] : '0;
endmodule

// File: tb/tb_iq_sample_fifo.sv
// tb_iq_sample_fifo: directed, table-driven check of iq_sample_fifo (DWIDTH=24, DEPTH=4, AFULL_LVL=3).
module tb_iq_sample_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    iq_sample_fifo_if #(.DWIDTH(24), .DEPTH(4)) bus ();

    iq_sample_fifo #(.DWIDTH(24), .DEPTH(4), .AFULL_LVL(3)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        push, pull, flush;
        logic [23:0] si, sq;
        logic        valid;
        logic [23:0] oi, oq;
        logic [2:0]  cnt;
        logic        stop, af, ovf, udf;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic pull, input logic flush,
                         input logic [23:0] si, input logic [23:0] sq);
        bus.PushIn  = push;
        bus.PullOut = pull;
        bus.Flush   = flush;
        bus.SampI   = si;
        bus.SampQ   = sq;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic valid, input logic [23:0] oi,
                               input logic [23:0] oq, input logic [2:0] cnt, input logic stop,
                               input logic af, input logic ovf, input logic udf);
        check({tag, ".ValidOut"},   32'(bus.ValidOut),   32'(valid));
        check({tag, ".OutI"},       32'(bus.OutI),       32'(oi));
        check({tag, ".OutQ"},       32'(bus.OutQ),       32'(oq));
        check({tag, ".Count"},      32'(bus.Count),      32'(cnt));
        check({tag, ".StopIn"},     32'(bus.StopIn),     32'(stop));
        check({tag, ".AlmostFull"}, 32'(bus.AlmostFull), 32'(af));
        check({tag, ".Overflow"},   32'(bus.Overflow),   32'(ovf));
        check({tag, ".Underflow"},  32'(bus.Underflow),  32'(udf));
    endtask

    initial begin
        logic [47:0] q [$];
        logic        up;
        logic        p, r;
        int          pushed;
        int          guard;

        //           push pull fl  si          sq           vld oi          oq          cnt   st  af  ov  ud
        vt[0]  = '{1'b1,1'b0,1'b0,24'h000001,24'hFFFFFF, 1'b1,24'h000001,24'hFFFFFF,3'd1,1'b0,1'b0,1'b0,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,24'h000002,24'h000002, 1'b1,24'h000001,24'hFFFFFF,3'd2,1'b0,1'b0,1'b0,1'b0};
        vt[2]  = '{1'b1,1'b0,1'b0,24'h000003,24'h000003, 1'b1,24'h000001,24'hFFFFFF,3'd3,1'b0,1'b1,1'b0,1'b0};
        vt[3]  = '{1'b1,1'b0,1'b0,24'h000004,24'h000004, 1'b1,24'h000001,24'hFFFFFF,3'd4,1'b1,1'b1,1'b0,1'b0};
        vt[4]  = '{1'b1,1'b0,1'b0,24'h000005,24'h000005, 1'b1,24'h000001,24'hFFFFFF,3'd4,1'b1,1'b1,1'b1,1'b0};
        vt[5]  = '{1'b0,1'b1,1'b0,24'h000000,24'h000000, 1'b1,24'h000002,24'h000002,3'd3,1'b0,1'b1,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b1,1'b0,24'h000000,24'h000000, 1'b1,24'h000003,24'h000003,3'd2,1'b0,1'b0,1'b1,1'b0};
        vt[7]  = '{1'b0,1'b1,1'b0,24'h000000,24'h000000, 1'b1,24'h000004,24'h000004,3'd1,1'b0,1'b0,1'b1,1'b0};
        vt[8]  = '{1'b0,1'b1,1'b0,24'h000000,24'h000000, 1'b0,24'h000000,24'h000000,3'd0,1'b0,1'b0,1'b1,1'b0};
        vt[9]  = '{1'b0,1'b1,1'b0,24'h000000,24'h000000, 1'b0,24'h000000,24'h000000,3'd0,1'b0,1'b0,1'b1,1'b1};
        vt[10] = '{1'b0,1'b0,1'b1,24'h000000,24'h000000, 1'b0,24'h000000,24'h000000,3'd0,1'b0,1'b0,1'b0,1'b0};
        vt[11] = '{1'b1,1'b0,1'b0,24'h000010,24'h000110, 1'b1,24'h000010,24'h000110,3'd1,1'b0,1'b0,1'b0,1'b0};
        vt[12] = '{1'b1,1'b0,1'b0,24'h000011,24'h000111, 1'b1,24'h000010,24'h000110,3'd2,1'b0,1'b0,1'b0,1'b0};
        vt[13] = '{1'b1,1'b0,1'b0,24'h000012,24'h000112, 1'b1,24'h000010,24'h000110,3'd3,1'b0,1'b1,1'b0,1'b0};
        vt[14] = '{1'b1,1'b0,1'b0,24'h000013,24'h000113, 1'b1,24'h000010,24'h000110,3'd4,1'b1,1'b1,1'b0,1'b0};
        vt[15] = '{1'b1,1'b1,1'b0,24'h000099,24'h000199, 1'b1,24'h000011,24'h000111,3'd3,1'b0,1'b1,1'b1,1'b0};
        vt[16] = '{1'b0,1'b0,1'b1,24'h000000,24'h000000, 1'b0,24'h000000,24'h000000,3'd0,1'b0,1'b0,1'b0,1'b0};
        vt[17] = '{1'b1,1'b1,1'b0,24'h00ABCD,24'h001234, 1'b1,24'h00ABCD,24'h001234,3'd1,1'b0,1'b0,1'b0,1'b1};
        vt[18] = '{1'b1,1'b1,1'b1,24'h000077,24'h000077, 1'b0,24'h000000,24'h000000,3'd0,1'b0,1'b0,1'b0,1'b0};

        drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        step();
        check_state("reset", 1'b0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].push, vt[i].pull, vt[i].flush, vt[i].si, vt[i].sq);
            step();
            check_state($sformatf("vec%0d", i), vt[i].valid, vt[i].oi, vt[i].oq, vt[i].cnt,
                        vt[i].stop, vt[i].af, vt[i].ovf, vt[i].udf);
        end

        // Wrap: occupancy swings 1..3 while ten pairs pass through, pointers wrap twice.
        up = 1'b1;
        pushed = 0;
        guard = 0;
        while ((pushed < 10 || q.size() > 0) && guard < 60) begin
            guard++;
            if (q.size() >= 3) up = 1'b0;
            else if (q.size() <= 1) up = 1'b1;
            p = up && pushed < 10;
            r = !p && q.size() > 0;
            drive(p, r, 1'b0, 24'h000100 + 24'(pushed), 24'h00F000 + 24'(pushed));
            step();
            if (r) void'(q.pop_front());
            if (p) begin
                q.push_back({24'h000100 + 24'(pushed), 24'h00F000 + 24'(pushed)});
                pushed++;
            end
            check("wrap.Count", 32'(bus.Count), 32'(q.size()));
            check("wrap.OutI", 32'(bus.OutI), q.size() > 0 ? 32'(q[0][47:24]) : 32'h0);
            check("wrap.OutQ", 32'(bus.OutQ), q.size() > 0 ? 32'(q[0][23:0]) : 32'h0);
        end
        check("wrap.done", 32'(pushed == 10 && q.size() == 0), 32'h1);

        // Flush with a push pending at Count=2 and Overflow set.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 24'h000020 + 24'(i), 24'h000030 + 24'(i));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
            step();
        end
        check_state("preflush", 1'b1, 24'h000022, 24'h000032, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 24'h000044, 24'h000044);
        step();
        check_state("flush", 1'b0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream, then first write lands and shows at the head.
        drive(1'b1, 1'b0, 1'b0, 24'h000055, 24'h000056);
        step();
        drive(1'b1, 1'b0, 1'b0, 24'h000057, 24'h000058);
        step();
        drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        check("pre_rst.Count", 32'(bus.Count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 24'h000066, 24'h000077);
        step();
        check_state("post_rst", 1'b1, 24'h000066, 24'h000077, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
